// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register for the MIPS core.
//
// Holds one fetched instruction and its PC in a main register, with a second
// skid register that catches a word accepted in the same cycle that decode
// stalls. if_ready is driven only from registered state, so there is no
// combinational path from id_ready back to fetch.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. The producer holds valid and its data steady
// until that edge, and valid never depends on ready in the same cycle.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   if_valid/if_ready   fetch-side handshake
//   if_instr, if_pc     fetched word and its address
//   flush               synchronous discard of held and incoming words
//   id_valid/id_ready   decode-side handshake
//   id_instr, id_pc     held word and its PC; id_pc_plus4 = id_pc + 4
//   id_opcode..id_target26  R/I/J field slices of id_instr
//   id_is_nop           held word is the all-zero NOP
//   drop_cnt            saturating count of valid words discarded by flush
module if_id_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  input  logic             flush,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc_plus4,
  output logic [5:0]       id_opcode,
  output logic [4:0]       id_rs,
  output logic [4:0]       id_rt,
  output logic [4:0]       id_rd,
  output logic [4:0]       id_shamt,
  output logic [5:0]       id_funct,
  output logic [15:0]      id_imm16,
  output logic [25:0]      id_target26,
  output logic             id_is_nop,
  output logic [CNT_W-1:0] drop_cnt
);

  logic        main_valid;
  logic [31:0] main_instr;
  logic [31:0] main_pc;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic             accept;
  logic             pop;
  logic [1:0]       drop_inc;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_next;

  assign if_ready = ~skid_valid;
  assign accept   = if_valid & if_ready;
  assign pop      = main_valid & id_ready;

  // Number of valid words a flush throws away this edge. accept implies the
  // skid is empty, so the sum never exceeds 2, but 2 bits cover any case.
  always_comb begin
    drop_inc  = {1'b0, main_valid} + {1'b0, skid_valid} + {1'b0, accept};
    drop_sum  = {1'b0, drop_cnt} + {{(CNT_W - 1){1'b0}}, drop_inc};
    drop_next = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid <= 1'b0;
      main_instr <= 32'h0;
      main_pc    <= PC_RESET;
      skid_valid <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc    <= PC_RESET;
      drop_cnt   <= '0;
    end else if (flush) begin
      // Data registers keep their contents; only the valid bits are cleared.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      drop_cnt   <= drop_next;
    end else if (pop && skid_valid) begin
      // if_ready is low here, so no accept can coincide.
      main_instr <= skid_instr;
      main_pc    <= skid_pc;
      skid_valid <= 1'b0;
    end else if (pop && accept) begin
      main_instr <= if_instr;
      main_pc    <= if_pc;
    end else if (pop) begin
      main_valid <= 1'b0;
    end else if (accept && !main_valid) begin
      main_valid <= 1'b1;
      main_instr <= if_instr;
      main_pc    <= if_pc;
    end else if (accept) begin
      // Decode stalled with main full: park the word in the skid register.
      skid_valid <= 1'b1;
      skid_instr <= if_instr;
      skid_pc    <= if_pc;
    end
  end

  assign id_valid    = main_valid;
  assign id_instr    = main_instr;
  assign id_pc       = main_pc;
  assign id_pc_plus4 = main_pc + 32'd4;
  assign id_opcode   = main_instr[31:26];
  assign id_rs       = main_instr[25:21];
  assign id_rt       = main_instr[20:16];
  assign id_rd       = main_instr[15:11];
  assign id_shamt    = main_instr[10:6];
  assign id_funct    = main_instr[5:0];
  assign id_imm16    = main_instr[15:0];
  assign id_target26 = main_instr[25:0];
  assign id_is_nop   = main_valid & (main_instr == 32'h0);

endmodule
